// File: rtl/tick_intr_ctrl.sv
// tick_intr_ctrl: AXI4-Lite interrupt controller for tick/event sources.
// Each source is latched into a sticky ISR bit. The bit is masked by IER and GIE
// and drives one registered irq line. Software clears pending bits through IACK.

// One interrupt source: input history, edge/level detect and the sticky status bit.
module tick_intr_bit #(
  parameter bit EDGE = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic src_i,
  input  logic clr_i,
  output logic isr_o,
  output logic pend_o
);
  logic src_q, isr_q, set;

  assign set = EDGE ? (src_i & ~src_q) : src_i;

  // Input history for edge detection; a new event beats a same-cycle clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_q <= 1'b0;
      isr_q <= 1'b0;
    end else begin
      src_q <= src_i;
      isr_q <= set | (isr_q & ~clr_i);
    end
  end

  assign isr_o  = isr_q;
  // Status as irq should see it after this cycle's clear. A clear that loses to
  // a set does not drop the bit, so irq does not glitch low.
  assign pend_o = isr_q & ~(clr_i & ~set);
endmodule

module tick_intr_ctrl #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 5,
  parameter int          C_NUM_OF_INTR      = 1,
  parameter logic [31:0] C_INTR_SENSITIVITY = 32'hFFFFFFFF,
  parameter int          C_IRQ_ACTIVE_STATE = 1
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_NUM_OF_INTR-1:0]        intr_src,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            irq
);
  localparam int   N       = C_NUM_OF_INTR;
  localparam int   DW      = C_S_AXI_DATA_WIDTH;
  localparam int   IW      = C_S_AXI_ADDR_WIDTH - 2;
  localparam logic IRQ_ACT = (C_IRQ_ACTIVE_STATE != 0);

  localparam logic [IW-1:0] A_GIE  = IW'(0);
  localparam logic [IW-1:0] A_IER  = IW'(1);
  localparam logic [IW-1:0] A_ISR  = IW'(2);
  localparam logic [IW-1:0] A_IACK = IW'(3);
  localparam logic [IW-1:0] A_IPR  = IW'(4);

  logic          gie_q, gie_d, irq_q, irq_d, bvalid_q, rvalid_q;
  logic [N-1:0]  ier_q, ier_d, isr, pend, clr;
  logic [DW-1:0] rdata_q, rd_val, wmask, wdat;
  logic [IW-1:0] aw_idx, ar_idx;
  logic          wr_hs, rd_hs;

  assign aw_idx = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

  // Address and data are accepted together, one write in flight. Reset holds ready low.
  assign wr_hs = S_AXI_ARESETN & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q;
  assign rd_hs = S_AXI_ARESETN & S_AXI_ARVALID & ~rvalid_q;

  assign S_AXI_AWREADY = wr_hs;
  assign S_AXI_WREADY  = wr_hs;
  assign S_AXI_ARREADY = rd_hs;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign irq           = IRQ_ACT ? irq_q : ~irq_q;

  for (genvar g = 0; g < N; g++) begin : g_src
    tick_intr_bit #(.EDGE(C_INTR_SENSITIVITY[g])) u_bit (
      .clk_i  (S_AXI_ACLK),
      .rst_ni (S_AXI_ARESETN),
      .src_i  (intr_src[g]),
      .clr_i  (clr[g]),
      .isr_o  (isr[g]),
      .pend_o (pend[g])
    );
  end

  // Register write decode with per-byte strobes; ISR and unmapped offsets ignore writes.
  always_comb begin
    wmask = '0;
    for (int b = 0; b < DW/8; b++) wmask[8*b +: 8] = {8{S_AXI_WSTRB[b]}};
    wdat  = S_AXI_WDATA & wmask;
    gie_d = gie_q;
    ier_d = ier_q;
    clr   = '0;
    if (wr_hs) begin
      case (aw_idx)
        A_GIE:   if (S_AXI_WSTRB[0]) gie_d = S_AXI_WDATA[0];
        A_IER:   ier_d = (ier_q & ~wmask[N-1:0]) | wdat[N-1:0];
        A_IACK:  clr = wdat[N-1:0];
        default: ;
      endcase
    end
  end

  // irq uses the post-write enables and clears, so it follows a write by one cycle.
  // New events still show up one cycle after they reach ISR.
  assign irq_d = gie_d & (|(pend & ier_d));

  // Read mux; unimplemented bits and offsets read 0.
  always_comb begin
    rd_val = '0;
    case (ar_idx)
      A_GIE:   rd_val[0]     = gie_q;
      A_IER:   rd_val[N-1:0] = ier_q;
      A_ISR:   rd_val[N-1:0] = isr;
      A_IPR:   rd_val[N-1:0] = isr & ier_q;
      default: ;
    endcase
  end

  // Control registers and the registered irq.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      gie_q <= 1'b0;
      ier_q <= '0;
      irq_q <= 1'b0;
    end else begin
      gie_q <= gie_d;
      ier_q <= ier_d;
      irq_q <= irq_d;
    end
  end

  // Response channels. Valids hold until the master is ready; RDATA is frozen while RVALID is high.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      if (wr_hs)             bvalid_q <= 1'b1;
      else if (S_AXI_BREADY) bvalid_q <= 1'b0;
      if (rd_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_val;
      end else if (S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Address LSBs are always zero for word access; high data bits beyond N have no storage.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], wdat, wmask};
endmodule

// File: tb/tb_tick_intr_ctrl.sv
// Directed bench for tick_intr_ctrl: 8 sources, source 1 level-sensitive, the rest edge.
module tb_tick_intr_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  src;
  logic [4:0]  awaddr, araddr;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        awready, wready, bvalid, arready, rvalid, irq;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tick_intr_ctrl #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (5),
    .C_NUM_OF_INTR      (8),
    .C_INTR_SENSITIVITY (32'hFFFFFFFD),
    .C_IRQ_ACTIVE_STATE (1)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .intr_src      (src),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .irq           (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Full write: src_hs is driven during the handshake cycle and src_after from the next one.
  // irq_hs is sampled in the handshake cycle and irq_b in the B cycle.
  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [7:0] src_hs, input logic [7:0] src_after,
                           output logic irq_hs, output logic irq_b);
    int n;
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    src = src_hs;
    n = 0;
    @(negedge clk);
    while (!awready && n < 20) begin @(negedge clk); n++; end
    chk("awready", {31'b0, awready}, 32'd1);
    chk("wready", {31'b0, wready}, 32'd1);
    irq_hs = irq;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; src = src_after;
    @(negedge clk);
    chk("bvalid", {31'b0, bvalid}, 32'd1);
    chk("bresp", {30'b0, bresp}, 32'd0);
    irq_b = irq;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    logic x, y;
    axi_write(a, d, s, 8'h00, 8'h00, x, y);
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    int n;
    @(posedge clk); #1;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready && n < 20) begin @(negedge clk); n++; end
    chk("arready", {31'b0, arready}, 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    chk("rvalid", {31'b0, rvalid}, 32'd1);
    chk("rresp", {30'b0, rresp}, 32'd0);
    chk(tag, rdata, exp);
    @(posedge clk); #1;
  endtask

  // One-cycle pulse, then wait until its irq effect is visible at the next negedge.
  task automatic pulse(input logic [7:0] bits);
    @(posedge clk); #1; src = bits;
    @(posedge clk); #1; src = 8'h00;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time exhausted, finish required earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ih, ib;
    rst_n = 1'b0; src = '0; awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    chk("rst_bvalid", {31'b0, bvalid}, 32'd0);
    chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    // All registers read zero after reset.
    rd_chk("rst_gie", 5'h00, 32'h0);
    rd_chk("rst_ier", 5'h04, 32'h0);
    rd_chk("rst_isr", 5'h08, 32'h0);
    rd_chk("rst_iack", 5'h0C, 32'h0);
    rd_chk("rst_ipr", 5'h10, 32'h0);

    // Edge on src0: irq two cycles after the edge, cleared one cycle after IACK.
    wr(5'h00, 32'h1, 4'hF);
    wr(5'h04, 32'h1, 4'hF);
    @(posedge clk); #1; src = 8'h01;
    @(negedge clk); chk("edge_n_irq", {31'b0, irq}, 32'd0);
    @(posedge clk); #1; src = 8'h00;
    @(negedge clk); chk("edge_n1_irq", {31'b0, irq}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("edge_n2_irq", {31'b0, irq}, 32'd1);
    rd_chk("edge_ipr", 5'h10, 32'h1);
    axi_write(5'h0C, 32'h1, 4'hF, 8'h00, 8'h00, ih, ib);
    chk("iack_irq_hs", {31'b0, ih}, 32'd1);
    chk("iack_irq_b", {31'b0, ib}, 32'd0);
    rd_chk("iack_ipr", 5'h10, 32'h0);

    // ISR latches while IER is off; enabling IER raises irq one cycle after the write.
    wr(5'h04, 32'h0, 4'hF);
    pulse(8'h01);
    @(negedge clk); chk("masked_irq", {31'b0, irq}, 32'd0);
    rd_chk("masked_isr", 5'h08, 32'h1);
    rd_chk("masked_ipr", 5'h10, 32'h0);
    axi_write(5'h04, 32'h1, 4'hF, 8'h00, 8'h00, ih, ib);
    chk("ier_en_irq_hs", {31'b0, ih}, 32'd0);
    chk("ier_en_irq_b", {31'b0, ib}, 32'd1);

    // New edge in the IACK handshake cycle wins: ISR stays set and irq never drops.
    axi_write(5'h0C, 32'h1, 4'hF, 8'h01, 8'h00, ih, ib);
    chk("race_irq_hs", {31'b0, ih}, 32'd1);
    chk("race_irq_b", {31'b0, ib}, 32'd1);
    @(negedge clk); chk("race_irq_after", {31'b0, irq}, 32'd1);
    rd_chk("race_isr", 5'h08, 32'h1);
    axi_write(5'h0C, 32'h1, 4'hF, 8'h00, 8'h00, ih, ib);
    chk("race_clr_irq_b", {31'b0, ib}, 32'd0);
    rd_chk("race_clr_isr", 5'h08, 32'h0);

    // Level source 1 held high: IACK cannot clear it until the source drops.
    wr(5'h04, 32'h2, 4'hF);
    @(posedge clk); #1; src = 8'h02;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk); chk("level_irq", {31'b0, irq}, 32'd1);
    axi_write(5'h0C, 32'h2, 4'hF, 8'h02, 8'h02, ih, ib);
    chk("level_iack_irq_b", {31'b0, ib}, 32'd1);
    rd_chk("level_isr", 5'h08, 32'h2);
    axi_write(5'h0C, 32'h2, 4'hF, 8'h00, 8'h00, ih, ib);
    chk("level_drop_irq_b", {31'b0, ib}, 32'd0);
    rd_chk("level_drop_isr", 5'h08, 32'h0);

    // Byte strobes, read-only ISR, unmapped offsets, GIE bit0 only.
    wr(5'h04, 32'hA5A5A5A5, 4'b0001);
    rd_chk("strb_ier", 5'h04, 32'h000000A5);
    wr(5'h04, 32'h0000FF00, 4'b0010);
    rd_chk("strb_hi_ier", 5'h04, 32'h000000A5);
    rd_chk("unmapped_rd", 5'h1C, 32'h0);
    wr(5'h08, 32'hFF, 4'hF);
    rd_chk("isr_ro", 5'h08, 32'h0);
    wr(5'h14, 32'hFFFFFFFF, 4'hF);
    wr(5'h00, 32'hFFFFFFFE, 4'hF);
    rd_chk("gie_off", 5'h00, 32'h0);

    // GIE gates irq; enabling it over a pending bit raises irq one cycle later.
    pulse(8'h01);
    @(negedge clk); chk("gie_off_irq", {31'b0, irq}, 32'd0);
    rd_chk("gie_off_ipr", 5'h10, 32'h1);
    axi_write(5'h00, 32'hFFFFFFFF, 4'hF, 8'h00, 8'h00, ih, ib);
    chk("gie_on_irq_b", {31'b0, ib}, 32'd1);
    rd_chk("gie_on", 5'h00, 32'h1);
    rd_chk("iack_reads0", 5'h0C, 32'h0);
    axi_write(5'h0C, 32'hFF, 4'hF, 8'h00, 8'h00, ih, ib);
    chk("gie_iack_irq_b", {31'b0, ib}, 32'd0);

    // Backpressure: responses hold and no new handshakes; then reset mid-hold.
    @(posedge clk); #1;
    awaddr = 5'h04; wdata = 32'h0F; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(negedge clk); chk("hold_aw_hs", {31'b0, awready}, 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; araddr = 5'h04; arvalid = 1'b1; rready = 1'b0;
    @(negedge clk);
    chk("hold_ar_hs", {31'b0, arready}, 32'd1);
    chk("hold_bvalid_first", {31'b0, bvalid}, 32'd1);
    @(posedge clk); #1;
    awaddr = 5'h04; wdata = 32'hF0; awvalid = 1'b1; wvalid = 1'b1; araddr = 5'h00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_bvalid", {31'b0, bvalid}, 32'd1);
      chk("hold_rvalid", {31'b0, rvalid}, 32'd1);
      chk("hold_rdata", rdata, 32'h0000000F);
      chk("hold_awready", {31'b0, awready}, 32'd0);
      chk("hold_arready", {31'b0, arready}, 32'd0);
      @(posedge clk); #1;
    end
    #2; rst_n = 1'b0;
    #1;
    chk("midrst_bvalid", {31'b0, bvalid}, 32'd0);
    chk("midrst_rvalid", {31'b0, rvalid}, 32'd0);
    chk("midrst_rdata", rdata, 32'h0);
    chk("midrst_awready", {31'b0, awready}, 32'd0);
    chk("midrst_arready", {31'b0, arready}, 32'd0);
    chk("midrst_irq", {31'b0, irq}, 32'd0);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk); chk("post_rst_bvalid", {31'b0, bvalid}, 32'd0);
    rd_chk("post_rst_ier", 5'h04, 32'h0);
    rd_chk("post_rst_gie", 5'h00, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
